chunk_gatherer: RTL and testbench

//  Serial-to-parallel front end for the chunk streamer. Accepts CHUNK_SIZE-bit chunks over
//  a valid/ready handshake and assembles them into a WORD_WIDTH-bit word. Chunk order

---
 rtl/chunk_gatherer_pkg.sv | 15 +
 rtl/chunk_gatherer_if.sv | 31 +++
 rtl/chunk_gatherer.sv | 112 +++++++++++
 tb/tb_chunk_gatherer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/chunk_gatherer_pkg.sv
// Shared helpers for the chunk gatherer and the chunk streamer benches.
//   num_chunks : number of CHUNK_SIZE slots in a word
//   slot_lsb   : least-significant bit position of slot k
package chunk_gatherer_pkg;

    function automatic int num_chunks(int w, int c);
        return w / c;
    endfunction

    // Slot 0 is the first chunk received; MSB-first puts it at the top of the word.
    function automatic int slot_lsb(int k, int n, int c, bit msb_first);
        return msb_first ? (n - 1 - k) * c : k * c;
    endfunction

endpackage

// File: rtl/chunk_gatherer_if.sv
// Handshake bundle for the chunk gatherer.
//   in_valid/in_ready/in_chunk/in_last : chunk input stream
//   out_valid/out_ready/out_word/out_chunks : assembled word output stream
// master = producer/consumer side, slave = gatherer side.
interface chunk_gatherer_if
    import chunk_gatherer_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int CHUNK_SIZE = 4
) ();
    localparam int CW = $clog2(num_chunks(WORD_WIDTH, CHUNK_SIZE) + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [CHUNK_SIZE-1:0] in_chunk;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_word;
    logic [CW-1:0]         out_chunks;

    modport master (
        output in_valid, in_chunk, in_last, out_ready,
        input  in_ready, out_valid, out_word, out_chunks
    );

    modport slave (
        input  in_valid, in_chunk, in_last, out_ready,
        output in_ready, out_valid, out_word, out_chunks
    );
endinterface

// File: rtl/chunk_gatherer.sv
// Serial-to-parallel chunk gatherer with one accumulate register and one
// output register, sustaining one chunk per cycle.
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : chunk_gatherer_if slave (input chunk stream, output word stream)
module chunk_gatherer
    import chunk_gatherer_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int CHUNK_SIZE = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    chunk_gatherer_if.slave bus
);
    localparam int NUM_CHUNKS = num_chunks(WORD_WIDTH, CHUNK_SIZE);
    localparam int CW         = $clog2(NUM_CHUNKS + 1);

    if (CHUNK_SIZE < 1 || (WORD_WIDTH % CHUNK_SIZE) != 0) begin : g_bad_params
        $fatal(1, "chunk_gatherer: WORD_WIDTH must be a multiple of CHUNK_SIZE");
    end

    logic [WORD_WIDTH-1:0] acc_q, acc_d, acc_ins;
    logic [CW-1:0]         count_q, count_d, count_inc;
    logic                  pending_q, pending_d;
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] out_word_q;
    logic [CW-1:0]         out_chunks_q;

    logic                  accept, complete, out_free, load;
    logic [WORD_WIDTH-1:0] load_word;
    logic [CW-1:0]         load_chunks;

    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready   = !pending_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = out_word_q;
    assign bus.out_chunks = out_chunks_q;

    assign accept    = bus.in_valid && !pending_q;
    assign count_inc = count_q + CW'(1);
    assign complete  = accept && (bus.in_last || (count_q == CW'(NUM_CHUNKS - 1)));
    assign out_free  = !out_valid_q || bus.out_ready;

    // Accumulator with the incoming chunk merged into slot count_q.
    always_comb begin
        acc_ins = acc_q;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (count_q == CW'(k)) begin
                acc_ins[slot_lsb(k, NUM_CHUNKS, CHUNK_SIZE, MSB_FIRST) +: CHUNK_SIZE] = bus.in_chunk;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        pending_d   = pending_q;
        load        = 1'b0;
        load_word   = acc_ins;
        load_chunks = count_inc;
        if (pending_q) begin
            // Parked word leaves as soon as the output register frees up.
            if (out_free) begin
                load        = 1'b1;
                load_word   = acc_q;
                load_chunks = count_q;
                acc_d       = '0;
                count_d     = '0;
                pending_d   = 1'b0;
            end
        end else if (accept) begin
            if (complete && out_free) begin
                load    = 1'b1;
                acc_d   = '0;
                count_d = '0;
            end else begin
                acc_d     = acc_ins;
                count_d   = count_inc;
                pending_d = complete;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_chunks_q <= '0;
        end else if (load) begin
            out_valid_q  <= 1'b1;
            out_word_q   <= load_word;
            out_chunks_q <= load_chunks;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chunk_gatherer.sv
module tb_chunk_gatherer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    chunk_gatherer_if #(.WORD_WIDTH(16), .CHUNK_SIZE(4)) ifa ();
    chunk_gatherer_if #(.WORD_WIDTH(16), .CHUNK_SIZE(4)) ifb ();
    chunk_gatherer_if #(.WORD_WIDTH(8),  .CHUNK_SIZE(1)) ifc ();

    // The LSB-first instance sees exactly the same stimulus as the MSB-first one.
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_chunk  = ifa.in_chunk;
    assign ifb.in_last   = ifa.in_last;
    assign ifb.out_ready = ifa.out_ready;

    chunk_gatherer #(.WORD_WIDTH(16), .CHUNK_SIZE(4), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    chunk_gatherer #(.WORD_WIDTH(16), .CHUNK_SIZE(4), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    chunk_gatherer #(.WORD_WIDTH(8),  .CHUNK_SIZE(1), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one chunk on dut_a/dut_b for one cycle (caller guarantees in_ready=1).
    task automatic send(input logic [3:0] c, input logic last);
        ifa.in_valid = 1'b1;
        ifa.in_chunk = c;
        ifa.in_last  = last;
        step();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
    endtask

    localparam int SOAK_WORDS = 300;
    logic [15:0] exp_word_q[$];
    int          exp_cnt_q[$];
    int          received;

    task automatic producer();
        for (int w = 0; w < SOAK_WORDS; w++) begin
            int          len;
            logic [15:0] word;
            logic        last_full;
            len       = $urandom_range(1, 4);
            last_full = 1'($urandom_range(0, 1));
            word      = '0;
            for (int k = 0; k < len; k++) begin
                logic [3:0] c;
                c = 4'($urandom_range(0, 15));
                word[(3 - k) * 4 +: 4] = c;
            end
            exp_word_q.push_back(word);
            exp_cnt_q.push_back(len);
            for (int k = 0; k < len; k++) begin
                int   guard;
                logic was_ready;
                repeat ($urandom_range(0, 2)) step();
                ifa.in_valid = 1'b1;
                ifa.in_chunk = word[(3 - k) * 4 +: 4];
                ifa.in_last  = (k == len - 1) && (len < 4 || last_full);
                guard = 0;
                do begin
                    was_ready = ifa.in_ready;
                    step();
                    guard++;
                end while (!was_ready && guard < 100);
                ifa.in_valid = 1'b0;
                ifa.in_last  = 1'b0;
                if (!was_ready) begin
                    chk("soak_in_ready_timeout", 32'(guard), 32'(0));
                    return;
                end
            end
        end
    endtask

    task automatic consumer();
        int cycles;
        cycles = 0;
        while (received < SOAK_WORDS && cycles < 20000) begin
            ifa.out_ready = 1'($urandom_range(0, 1));
            if (ifa.out_valid && ifa.out_ready) begin
                if (exp_word_q.size() == 0) begin
                    chk("soak_unexpected_word", 32'(ifa.out_word), 32'hFFFF_FFFF);
                end else begin
                    chk("soak_word",   32'(ifa.out_word),   32'(exp_word_q.pop_front()));
                    chk("soak_chunks", 32'(ifa.out_chunks), 32'(exp_cnt_q.pop_front()));
                end
                received++;
            end
            step();
            cycles++;
        end
        ifa.out_ready = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.in_chunk  = '0;
        ifa.in_last   = 1'b0;
        ifa.out_ready = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_chunk  = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;
        received      = 0;
        step();
        step();

        chk("rst_out_valid",  32'(ifa.out_valid),  32'h0);
        chk("rst_out_word",   32'(ifa.out_word),   32'h0);
        chk("rst_out_chunks", 32'(ifa.out_chunks), 32'h0);
        chk("rst_in_ready",   32'(ifa.in_ready),   32'h1);
        rst_n = 1'b1;
        step();

        // Full word, back-to-back, both chunk orders.
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        chk("t1_no_early_valid", 32'(ifa.out_valid), 32'h0);
        send(4'hD, 1'b0);
        chk("t1_valid",     32'(ifa.out_valid),  32'h1);
        chk("t1_word_msb",  32'(ifa.out_word),   32'hABCD);
        chk("t1_chunks",    32'(ifa.out_chunks), 32'h4);
        chk("t2_word_lsb",  32'(ifb.out_word),   32'hDCBA);
        step();
        chk("t1_valid_drop", 32'(ifa.out_valid), 32'h0);

        // Partial word closed by in_last.
        send(4'h1, 1'b0);
        send(4'h2, 1'b1);
        chk("t3_word_msb", 32'(ifa.out_word),   32'h1200);
        chk("t3_chunks",   32'(ifa.out_chunks), 32'h2);
        chk("t3_word_lsb", 32'(ifb.out_word),   32'h0021);
        step();

        // Output stalled: second word parks in the accumulator.
        ifa.out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        chk("t4_first_word", 32'(ifa.out_word), 32'h1234);
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        send(4'h7, 1'b0);
        send(4'h8, 1'b0);
        chk("t4_in_ready_low", 32'(ifa.in_ready),  32'h0);
        chk("t4_hold_word",    32'(ifa.out_word),  32'h1234);
        step();
        chk("t4_hold_valid",   32'(ifa.out_valid), 32'h1);
        chk("t4_hold_word2",   32'(ifa.out_word),  32'h1234);
        ifa.out_ready = 1'b1;
        step();
        chk("t4_no_bubble",    32'(ifa.out_valid), 32'h1);
        chk("t4_second_word",  32'(ifa.out_word),  32'h5678);
        chk("t4_in_ready_back",32'(ifa.in_ready),  32'h1);
        step();
        chk("t4_drained",      32'(ifa.out_valid), 32'h0);

        // Drain and completion in the same cycle, no pending stage.
        ifa.out_ready = 1'b0;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        send(4'h9, 1'b0);
        send(4'h8, 1'b0);
        send(4'h7, 1'b0);
        ifa.out_ready = 1'b1;
        send(4'h6, 1'b0);
        chk("sim_valid",    32'(ifa.out_valid), 32'h1);
        chk("sim_word",     32'(ifa.out_word),  32'h9876);
        chk("sim_in_ready", 32'(ifa.in_ready),  32'h1);
        step();
        chk("sim_drained",  32'(ifa.out_valid), 32'h0);

        // Reset discards a partial word.
        send(4'h9, 1'b0);
        send(4'hA, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_valid", 32'(ifa.out_valid), 32'h0);
        step();
        chk("t5_idle_valid", 32'(ifa.out_valid), 32'h0);
        send(4'hB, 1'b0);
        send(4'hC, 1'b0);
        send(4'hD, 1'b0);
        send(4'hE, 1'b0);
        chk("t5_word_msb", 32'(ifa.out_word),   32'hBCDE);
        chk("t5_chunks",   32'(ifa.out_chunks), 32'h4);
        chk("t5_word_lsb", 32'(ifb.out_word),   32'hEDCB);
        step();

        // 1-bit chunks into an 8-bit word.
        begin
            logic [7:0] bits;
            bits = 8'b1011_0010;
            for (int i = 7; i >= 0; i--) begin
                ifc.in_valid = 1'b1;
                ifc.in_chunk = bits[i];
                step();
            end
            ifc.in_valid = 1'b0;
        end
        chk("t6_valid",  32'(ifc.out_valid),  32'h1);
        chk("t6_word",   32'(ifc.out_word),   32'hB2);
        chk("t6_chunks", 32'(ifc.out_chunks), 32'h8);
        step();

        // Random stalls on both sides against a queue of expected words.
        fork
            producer();
            consumer();
        join
        chk("soak_received", 32'(received), 32'(SOAK_WORDS));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
